afifo_level: RTL and testbench

Parametrised dual-clock FIFO with level reporting, the successor to the current 4-entry async FIFO. It carries Width-bit words from the wclk domain to the rclk domain at any power-of-two depth. It also provides per-side occupancy counts, programmable almost-empty and almost-full flags, and sticky overflow and underflow flags. It sits between capture logic running on the write PLL clock and consumers running on the read PLL clock.

---
 rtl/afifo_pkg.sv | 33 +++
 rtl/gray_sync.sv | 32 +++
 rtl/afifo_level.sv | 153 +++++++++++++++
 tb/tb_afifo_level.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
`timescale 1ns/1ps
// afifo_pkg: shared constants and Gray-code helpers for the afifo_level
// dual-clock FIFO.
//   SyncStages : depth of each clock-domain-crossing synchronizer
//   bin2gray   : binary to reflected Gray code
//   gray2bin   : reflected Gray code to binary
// The helpers work on a 32-bit container. Callers zero-extend an (A+1)-bit
// pointer into it and truncate the result back. Zero upper bits do not
// change either conversion, so one function pair serves every FIFO depth.
package afifo_pkg;

  localparam int SyncStages = 2;
  localparam int MaxPtrW    = 32;

  typedef logic [MaxPtrW-1:0] gptr_t;

  function automatic gptr_t bin2gray(input gptr_t b);
    return b ^ (b >> 1);
  endfunction

  // The prefix XOR from the MSB down is built with log2 shift steps.
  function automatic gptr_t gray2bin(input gptr_t g);
    gptr_t b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
`timescale 1ns/1ps
// gray_sync: multi-bit synchronizer for a Gray-coded pointer entering a new
// clock domain. It has SyncStages flops in series and resets asynchronously
// to zero.
//   clk_i   : destination clock
//   rst_n_i : destination-side reset, asynchronous, active-low
//   d_i     : Gray pointer from the source domain
//   q_o     : synchronized Gray pointer
module gray_sync
  import afifo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [SyncStages-1:0][N-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SyncStages-2:0], d_i};
    end
  end

  assign q_o = stage_q[SyncStages-1];

endmodule

// File: rtl/afifo_level.sv
`timescale 1ns/1ps
// afifo_level: dual-clock FIFO with show-ahead read, per-side occupancy
// counts, almost-empty/almost-full flags and sticky overflow/underflow flags.
//   Read side  (rclk, rrst_): r pop request, rd head word, rempty,
//                             ralmostempty, rcount, runderflow
//   Write side (wclk, wrst_): w push request, wd push data, wfull,
//                             walmostfull, wcount, woverflow
// Each side keeps an (A+1)-bit binary pointer and its Gray copy. Only the
// Gray copy crosses to the other side, through gray_sync. Because the
// synchronized view of the far pointer always lags, rcount can only
// under-report and wcount can only over-report.
module afifo_level
  import afifo_pkg::*;
#(
  parameter int Width       = 16,
  parameter int Size        = 16,
  parameter int AEmptyLevel = 2,
  parameter int AFullLevel  = Size - 2
) (
  input  logic                  rclk,
  input  logic                  rrst_,
  input  logic                  wclk,
  input  logic                  wrst_,
  input  logic                  r,
  output logic [Width-1:0]      rd,
  output logic                  rempty,
  output logic                  ralmostempty,
  output logic [$clog2(Size):0] rcount,
  output logic                  runderflow,
  input  logic                  w,
  input  logic [Width-1:0]      wd,
  output logic                  wfull,
  output logic                  walmostfull,
  output logic [$clog2(Size):0] wcount,
  output logic                  woverflow
);

  localparam int A = $clog2(Size);
  localparam int P = A + 1;

  typedef logic [P-1:0] aptr_t;

  localparam aptr_t AEmptyLvl = aptr_t'(AEmptyLevel);
  localparam aptr_t AFullLvl  = aptr_t'(AFullLevel);

  function automatic aptr_t to_gray(input aptr_t b);
    return aptr_t'(bin2gray(gptr_t'(b)));
  endfunction

  function automatic aptr_t to_bin(input aptr_t g);
    return aptr_t'(gray2bin(gptr_t'(g)));
  endfunction

  logic [Width-1:0] mem_q [Size];

  // ---------------- write side ----------------
  aptr_t wbin_q, wbin_d, wgray_q, wgray_d, wcount_q, wcount_d, rgray_sync;
  logic  wfull_q, wfull_d, walmostfull_q, walmostfull_d, woverflow_q, push;

  always_comb begin
    push          = w & ~wfull_q;
    wbin_d        = wbin_q + aptr_t'(push);
    wgray_d       = to_gray(wbin_d);
    // Full means the write pointer is a whole lap ahead of the read pointer.
    // In Gray code that shows as the top two bits inverted.
    wfull_d       = (wgray_d == {~rgray_sync[A:A-1], rgray_sync[A-2:0]});
    wcount_d      = wbin_d - to_bin(rgray_sync);
    walmostfull_d = (wcount_d >= AFullLvl);
  end

  always_ff @(posedge wclk or negedge wrst_) begin
    if (!wrst_) begin
      wbin_q        <= '0;
      wgray_q       <= '0;
      wfull_q       <= 1'b0;
      walmostfull_q <= (AFullLevel == 0);
      wcount_q      <= '0;
      woverflow_q   <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wgray_q       <= wgray_d;
      wfull_q       <= wfull_d;
      walmostfull_q <= walmostfull_d;
      wcount_q      <= wcount_d;
      woverflow_q   <= woverflow_q | (w & wfull_q);
    end
  end

  // The array has no reset. A flush only has to rewind the pointers.
  always_ff @(posedge wclk) begin
    if (push) begin
      mem_q[wbin_q[A-1:0]] <= wd;
    end
  end

  gray_sync #(.N(P)) u_rgray_sync (
    .clk_i   (wclk),
    .rst_n_i (wrst_),
    .d_i     (rgray_q),
    .q_o     (rgray_sync)
  );

  // ---------------- read side ----------------
  aptr_t rbin_q, rbin_d, rgray_q, rgray_d, rcount_q, rcount_d, wgray_sync;
  logic  rempty_q, rempty_d, ralmostempty_q, ralmostempty_d, runderflow_q, pop;

  always_comb begin
    pop            = r & ~rempty_q;
    rbin_d         = rbin_q + aptr_t'(pop);
    rgray_d        = to_gray(rbin_d);
    rempty_d       = (rgray_d == wgray_sync);
    rcount_d       = to_bin(wgray_sync) - rbin_d;
    ralmostempty_d = (rcount_d <= AEmptyLvl);
  end

  always_ff @(posedge rclk or negedge rrst_) begin
    if (!rrst_) begin
      rbin_q         <= '0;
      rgray_q        <= '0;
      rempty_q       <= 1'b1;
      ralmostempty_q <= 1'b1;
      rcount_q       <= '0;
      runderflow_q   <= 1'b0;
    end else begin
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      rempty_q       <= rempty_d;
      ralmostempty_q <= ralmostempty_d;
      rcount_q       <= rcount_d;
      runderflow_q   <= runderflow_q | (r & rempty_q);
    end
  end

  gray_sync #(.N(P)) u_wgray_sync (
    .clk_i   (rclk),
    .rst_n_i (rrst_),
    .d_i     (wgray_q),
    .q_o     (wgray_sync)
  );

  // Show-ahead read: the head word is read combinationally from the array.
  assign rd           = mem_q[rbin_q[A-1:0]];
  assign rempty       = rempty_q;
  assign ralmostempty = ralmostempty_q;
  assign rcount       = rcount_q;
  assign runderflow   = runderflow_q;

  assign wfull        = wfull_q;
  assign walmostfull  = walmostfull_q;
  assign wcount       = wcount_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_afifo_level.sv
`timescale 1ns/1ps
module tb_afifo_level;

  localparam int S = 8;

  logic        rclk = 1'b0, wclk = 1'b0;
  logic        rrst_ = 1'b0, wrst_ = 1'b0;
  logic        r = 1'b0, w = 1'b0;
  logic [15:0] wd = '0;
  logic [15:0] rd;
  logic        rempty, ralmostempty, runderflow, wfull, walmostfull, woverflow;
  logic [3:0]  rcount, wcount;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words in push order, accepted push/pop totals, and the
  // expected state of the sticky flags.
  logic [15:0] q[$];
  int          n_push, n_pop, wfull_rises;
  bit          ovf_m, unf_m;

  afifo_level #(.Width(16), .Size(S), .AEmptyLevel(2), .AFullLevel(6)) dut (
    .rclk(rclk), .rrst_(rrst_), .wclk(wclk), .wrst_(wrst_),
    .r(r), .rd(rd), .rempty(rempty), .ralmostempty(ralmostempty),
    .rcount(rcount), .runderflow(runderflow),
    .w(w), .wd(wd), .wfull(wfull), .walmostfull(walmostfull),
    .wcount(wcount), .woverflow(woverflow)
  );

  always #10 wclk = ~wclk;     // 50 MHz
  always #5.556 rclk = ~rclk;  // ~90 MHz

  task automatic assert_resets(input int dur_ns);
    w = 1'b0; r = 1'b0;
    rrst_ = 1'b0; wrst_ = 1'b0;
    q.delete(); n_push = 0; n_pop = 0; ovf_m = 0; unf_m = 0;
    #(dur_ns);
  endtask

  task automatic release_resets();
    @(negedge wclk) wrst_ = 1'b1;
    @(negedge rclk) rrst_ = 1'b1;
    repeat (2) @(negedge wclk);
  endtask

  task automatic test_reset();
    logic [13:0] got;
    assert_resets(200);
    got = {rempty, ralmostempty, runderflow, wfull, walmostfull, woverflow, rcount, wcount};
    n_vec++;
    if (got !== {6'b110000, 8'h00}) begin
      n_err++; $display("FAIL reset_during flags got %b want %b", got, {6'b110000, 8'h00});
    end
    release_resets();
    got = {rempty, ralmostempty, runderflow, wfull, walmostfull, woverflow, rcount, wcount};
    n_vec++;
    if (got !== {6'b110000, 8'h00}) begin
      n_err++; $display("FAIL reset_after flags got %b want %b", got, {6'b110000, 8'h00});
    end
  endtask

  task automatic test_fill();
    int k;
    for (int i = 1; i <= 9; i++) begin
      @(negedge wclk); w = 1'b1; wd = 16'(i);
      if (i <= S) begin q.push_back(16'(i)); n_push++; end
      @(posedge wclk); #1;
      n_vec++;
      if (wcount !== 4'(i > S ? S : i) || walmostfull !== (i >= 6) ||
          wfull !== (i >= S) || woverflow !== (i == 9)) begin
        n_err++;
        $display("FAIL fill[%0d] wcount/waf/wfull/wovf got %0d/%b/%b/%b want %0d/%b/%b/%b",
                 i, wcount, walmostfull, wfull, woverflow, (i > S ? S : i), (i >= 6), (i >= S), (i == 9));
      end
    end
    @(negedge wclk); w = 1'b0;
    k = 0;
    while (rcount !== 4'd8 && k < 6) begin @(negedge rclk); k++; end
    n_vec++;
    if (rcount !== 4'd8 || rempty !== 1'b0 || rd !== 16'h0001) begin
      n_err++; $display("FAIL fill_rside rcount/rempty/rd got %0d/%b/%h want 8/0/0001", rcount, rempty, rd);
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= S; k++) begin
      @(negedge rclk);
      n_vec++;
      if (rd !== 16'(k) || rempty !== 1'b0) begin
        n_err++; $display("FAIL drain_data[%0d] rd/rempty got %h/%b want %h/0", k, rd, rempty, 16'(k));
      end
      void'(q.pop_front()); n_pop++;
      r = 1'b1;
      @(posedge rclk); #1;
      n_vec++;
      if (rcount !== 4'(S - k) || ralmostempty !== ((S - k) <= 2) || rempty !== (k == S)) begin
        n_err++;
        $display("FAIL drain_flags[%0d] rcount/rae/rempty got %0d/%b/%b want %0d/%b/%b",
                 k, rcount, ralmostempty, rempty, S - k, ((S - k) <= 2), (k == S));
      end
    end
    // r is still high with the FIFO empty: one underflowing pop request.
    @(posedge rclk); #1;
    n_vec++;
    if (runderflow !== 1'b1 || rempty !== 1'b1 || rcount !== 4'd0) begin
      n_err++; $display("FAIL underflow runf/rempty/rcount got %b/%b/%0d want 1/1/0", runderflow, rempty, rcount);
    end
    @(negedge rclk); r = 1'b0;
    repeat (6) @(negedge wclk);
    n_vec++;
    if (wcount !== 4'd0 || walmostfull !== 1'b0 || wfull !== 1'b0 || woverflow !== 1'b1) begin
      n_err++;
      $display("FAIL drain_wside wcount/waf/wfull/wovf got %0d/%b/%b/%b want 0/0/0/1",
               wcount, walmostfull, wfull, woverflow);
    end
  endtask

  // Traffic engine. mode 0: streaming counter, 1: reader pops 1 in 5 cycles,
  // 2: random w/r with random data (overflow/underflow attempts included).
  task automatic run_traffic(input int mode, input int nwords, input int budget);
    int          wr_n, rd_n;
    logic [15:0] ctr, exp;
    bit          prev_full;
    wr_n = 0; rd_n = 0; ctr = 16'h0; prev_full = 0; wfull_rises = 0;
    fork
      begin
        for (int c = 0; c < budget && wr_n < nwords; c++) begin
          @(negedge wclk);
          n_vec++;
          if (woverflow !== ovf_m) begin
            n_err++; $display("FAIL traffic_wovf got %b want %b", woverflow, ovf_m);
          end
          n_vec++;
          if (int'(wcount) < n_push - n_pop || int'(wcount) > S) begin
            n_err++; $display("FAIL traffic_wcount got %0d want %0d..%0d", wcount, n_push - n_pop, S);
          end
          if (wfull && !prev_full) wfull_rises++;
          prev_full = wfull;
          w  = (mode == 2) ? 1'($urandom_range(1)) : !wfull;
          wd = (mode == 0) ? ctr : 16'($urandom);
          if (w && wfull) ovf_m = 1;
          if (w && !wfull) begin q.push_back(wd); n_push++; wr_n++; ctr++; end
        end
        @(negedge wclk); w = 1'b0;
        n_vec++;
        if (wr_n != nwords) begin
          n_err++; $display("FAIL traffic_wtimeout pushed %0d want %0d", wr_n, nwords);
        end
      end
      begin
        for (int c = 0; c < budget && rd_n < nwords; c++) begin
          @(negedge rclk);
          n_vec++;
          if (runderflow !== unf_m) begin
            n_err++; $display("FAIL traffic_runf got %b want %b", runderflow, unf_m);
          end
          n_vec++;
          if (int'(rcount) > n_push - n_pop || (!rempty && q.size() == 0)) begin
            n_err++;
            $display("FAIL traffic_rcount rcount/rempty got %0d/%b want <=%0d, queued %0d",
                     rcount, rempty, n_push - n_pop, q.size());
          end
          case (mode)
            0:       r = !rempty;
            1:       r = !rempty && (c % 5 == 0);
            default: r = 1'($urandom_range(1));
          endcase
          if (r && rempty) unf_m = 1;
          if (r && !rempty && q.size() > 0) begin
            exp = q.pop_front(); n_pop++; rd_n++;
            n_vec++;
            if (rd !== exp) begin
              n_err++; $display("FAIL traffic_data[%0d] rd got %h want %h", rd_n, rd, exp);
            end
          end
        end
        @(negedge rclk); r = 1'b0;
        n_vec++;
        if (rd_n != nwords) begin
          n_err++; $display("FAIL traffic_rtimeout popped %0d want %0d", rd_n, nwords);
        end
      end
    join
  endtask

  task automatic test_stream();
    assert_resets(100);
    release_resets();
    run_traffic(0, 10000, 40000);
    n_vec++;
    if (woverflow !== 1'b0 || runderflow !== 1'b0 || q.size() != 0) begin
      n_err++; $display("FAIL stream_end wovf/runf/left got %b/%b/%0d want 0/0/0", woverflow, runderflow, q.size());
    end
  endtask

  task automatic test_backpressure();
    assert_resets(100);
    release_resets();
    run_traffic(1, 300, 20000);
    n_vec++;
    if (wfull_rises < 2 || woverflow !== 1'b0) begin
      n_err++; $display("FAIL backpressure wfull_rises/wovf got %0d/%b want >=2/0", wfull_rises, woverflow);
    end
  endtask

  task automatic test_random();
    assert_resets(100);
    release_resets();
    run_traffic(2, 1500, 20000);
    n_vec++;
    if (q.size() != 0 || rempty !== 1'b1) begin
      n_err++; $display("FAIL random_end left/rempty got %0d/%b want 0/1", q.size(), rempty);
    end
  endtask

  task automatic test_flush();
    logic [13:0] got;
    int k;
    assert_resets(100);
    release_resets();
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk); w = 1'b1; wd = 16'($urandom);
    end
    @(negedge wclk); w = 1'b0;
    k = 0;
    while (rcount !== 4'd5 && k < 10) begin @(negedge rclk); k++; end
    n_vec++;
    if (rcount !== 4'd5 || wcount !== 4'd5) begin
      n_err++; $display("FAIL flush_prefill rcount/wcount got %0d/%0d want 5/5", rcount, wcount);
    end
    assert_resets(50);
    got = {rempty, ralmostempty, runderflow, wfull, walmostfull, woverflow, rcount, wcount};
    n_vec++;
    if (got !== {6'b110000, 8'h00}) begin
      n_err++; $display("FAIL flush_during flags got %b want %b", got, {6'b110000, 8'h00});
    end
    #50;
    release_resets();
    got = {rempty, ralmostempty, runderflow, wfull, walmostfull, woverflow, rcount, wcount};
    n_vec++;
    if (got !== {6'b110000, 8'h00}) begin
      n_err++; $display("FAIL flush_after flags got %b want %b", got, {6'b110000, 8'h00});
    end
    @(negedge wclk); w = 1'b1; wd = 16'hBEEF;
    @(negedge wclk); w = 1'b0;
    k = 0;
    while (rempty !== 1'b0 && k < 10) begin @(negedge rclk); k++; end
    n_vec++;
    if (rempty !== 1'b0 || rd !== 16'hBEEF || rcount !== 4'd1) begin
      n_err++; $display("FAIL flush_first rempty/rd/rcount got %b/%h/%0d want 0/beef/1", rempty, rd, rcount);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
